// File: rtl/hilo_md_seq.sv
// HI/LO multiply-divide sequencer: multi-cycle MULT/DIV with E-stage stall.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset
//   start      : HI/LO operation request (HILOwe)
//   op [2:0]   : MULT/MULTU/DIV/DIVU/MTHI/MTLO, 11x = no-op
//   a, b       : rs / rt operands
//   rd_req     : MFHI/MFLO present in E stage
//   flush      : cancel the in-flight operation
//   busy       : multi-cycle operation in progress
//   stall      : freeze request to F/D/E
//   hi, lo     : architectural HI / LO registers
module hilo_md_seq #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_req,
   input  logic        flush,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   localparam logic [4:0] LP_MC = 5'(MULT_CYCLES);
   localparam logic [4:0] LP_DC = 5'(DIV_CYCLES);

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic        r_busy;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_res_hi;
   logic [31:0] r_res_lo;

   // op[0] clear selects the signed variant of MULT/DIV
   logic        w_sgn;
   assign w_sgn = ~op[0];

   // Multiply: the low 64 bits of a 64x64 product of sign- or
   // zero-extended operands equal the 32x32 signed/unsigned product.
   logic [63:0] w_ax;
   logic [63:0] w_bx;
   logic [63:0] w_prod;
   assign w_ax   = w_sgn ? {{32{a[31]}}, a} : {32'd0, a};
   assign w_bx   = w_sgn ? {{32{b[31]}}, b} : {32'd0, b};
   assign w_prod = w_ax * w_bx;

   // Divide on magnitudes, then restore signs. This keeps
   // 0x80000000 / -1 well defined: the magnitude 0x80000000
   // negates back to itself, giving quotient 0x80000000, rem 0.
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic        w_div0;
   logic [31:0] w_div_hi;
   logic [31:0] w_div_lo;

   assign w_a_neg = w_sgn & a[31];
   assign w_b_neg = w_sgn & b[31];
   assign w_a_mag = w_a_neg ? (32'd0 - a) : a;
   assign w_b_mag = w_b_neg ? (32'd0 - b) : b;
   assign w_div0  = (b == 32'd0);
   assign w_q_mag = w_div0 ? 32'd0 : (w_a_mag / w_b_mag);
   assign w_r_mag = w_div0 ? 32'd0 : (w_a_mag % w_b_mag);
   assign w_quo   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
   // remainder carries the sign of the dividend
   assign w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

   // divide by zero: all-ones quotient, dividend as remainder
   assign w_div_lo = w_div0 ? 32'hFFFF_FFFF : w_quo;
   assign w_div_hi = w_div0 ? a : w_rem;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= 5'd0;
         r_busy   <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_res_hi <= 32'd0;
         r_res_lo <= 32'd0;
      end else if (flush) begin
         // pending result is dropped; hi/lo stay as they are
         r_state <= S_IDLE;
         r_cnt   <= 5'd0;
         r_busy  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  unique case (op)
                     3'b000, 3'b001: begin
                        r_res_hi <= w_prod[63:32];
                        r_res_lo <= w_prod[31:0];
                        r_cnt    <= LP_MC;
                        r_state  <= S_MUL;
                        r_busy   <= 1'b1;
                     end
                     3'b010, 3'b011: begin
                        r_res_hi <= w_div_hi;
                        r_res_lo <= w_div_lo;
                        r_cnt    <= LP_DC;
                        r_state  <= S_DIV;
                        r_busy   <= 1'b1;
                     end
                     3'b100: r_hi <= a;
                     3'b101: r_lo <= a;
                     default: ;
                  endcase
               end
            end
            S_MUL, S_DIV: begin
               if (r_cnt == 5'd1) begin
                  r_hi    <= r_res_hi;
                  r_lo    <= r_res_lo;
                  r_cnt   <= 5'd0;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= 5'd0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // a start seen while busy is only stalled, never queued
   assign busy  = r_busy;
   assign stall = r_busy & (start | rd_req);
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule

// File: doc/hilo_md_seq.md
HILO_MD_SEQ -- requirements
Module: hilo_md_seq

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for MULT/MULTU (legal range 1..31).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU (legal range 1..31).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  HI/LO operation request from the E stage (HILOwe).
REQ-006 The block SHALL have port op  input  3  operation code: MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101; 110/111 no-op.
REQ-007 The block SHALL have port a  input  32  rs operand (dividend/multiplicand, or MTHI/MTLO data).
REQ-008 The block SHALL have port b  input  32  rt operand (divisor/multiplier).
REQ-009 The block SHALL have port rd_req  input  1  E-stage MFHI/MFLO present.
REQ-010 The block SHALL have port flush  input  1  exception/ERET cancel of the in-flight operation.
REQ-011 The block SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-012 The block SHALL have port stall  output  1  freeze request to the F/D/E stages.
REQ-013 The block SHALL have port hi  output  32  architectural HI register.
REQ-014 The block SHALL have port lo  output  32  architectural LO register.

Function
REQ-015 FSM states SHALL be IDLE, MUL, DIV; busy = (state != IDLE).
REQ-016 In IDLE, start with op MULT/MULTU SHALL latch the 64-bit product (signed/unsigned), load counter with MULT_CYCLES, and enter MUL at the next edge.
REQ-017 In IDLE, start with op DIV/DIVU SHALL latch quotient and remainder, load counter with DIV_CYCLES, and enter DIV at the next edge.
REQ-018 Counter SHALL decrement once per cycle in MUL/DIV; in the cycle it equals 1, hi/lo SHALL update at that edge and state SHALL return to IDLE.
REQ-019 Latency: start accepted in cycle T gives busy=1 in cycles T+1..T+N, new hi/lo and busy=0 visible in cycle T+N+1 (N = MULT_CYCLES or DIV_CYCLES).
REQ-020 MULT/MULTU result: hi = product[63:32], lo = product[31:0].
REQ-021 DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend; 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-022 DIVU: unsigned quotient to lo, unsigned remainder to hi.
REQ-023 Divide by zero (b=0, DIV or DIVU) SHALL give lo=0xFFFFFFFF, hi=a after the full DIV_CYCLES, with no exception.
REQ-024 In IDLE, start with MTHI (MTLO) SHALL write a to hi (lo) at the next edge, with busy staying 0; the other register SHALL be unchanged.
REQ-025 start with op 110/111 SHALL have no effect.
REQ-026 stall = busy & (start | rd_req), combinational; start while busy SHALL NOT be accepted or queued.
REQ-027 When the last busy cycle coincides with start, the block SHALL assert stall that cycle and accept the new start in the following IDLE cycle.
REQ-028 flush in any state SHALL force IDLE at the next edge, discard the pending result, and leave hi/lo unchanged.
REQ-029 flush SHALL override a same-cycle start and a same-cycle final count; no write SHALL occur.
REQ-030 Operands a/b SHALL be sampled only in the start-accept cycle; later changes SHALL NOT affect the result.

Reset
REQ-031 reset SHALL have priority over flush and start, and SHALL force state=IDLE, counter=0, hi=0, lo=0, busy=0, stall=0 at the next edge.
REQ-032 reset asserted mid-operation SHALL discard the pending result.

Verification
REQ-033 MULT a=0xFFFFFFFE, b=3 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-035 rd_req=1 in the cycle after the DIV start -> stall=1 for cycles T+1..T+10 and stall=0 at T+11 with the new hi/lo visible.
REQ-036 MTHI a=0x12345678 in IDLE -> hi=0x12345678 the next cycle, lo unchanged, busy never asserted.
REQ-037 MULT start, then flush in the 3rd busy cycle -> IDLE the next cycle and hi/lo keep their old values; repeat with flush in the final count cycle -> no write.
REQ-038 reset asserted in the 4th busy cycle of a DIV -> hi=lo=0, busy=0 the next cycle, and no late write.
